rle_stream_arb: RTL

RLE_STREAM_ARB -- requirements
Module: rle_stream_arb

---
 rtl/rle_stream_arb_if.sv | 29 ++
 rtl/rle_stream_arb.sv | 120 ++++++++++++
 2 files changed

// File: rtl/rle_stream_arb_if.sv
// rtl/rle_stream_arb_if.sv - FIFO-pair and encoder handshake bundle for rle_stream_arb
// master = arbiter side, slave = FIFO/encoder side.
interface rle_stream_arb_if;
  logic       recv_ready0;
  logic       recv_ready1;
  logic [7:0] in_data0;
  logic [7:0] in_data1;
  logic       eos0;
  logic       eos1;
  logic       rd_req0;
  logic       rd_req1;
  logic       enc_recv_ready;
  logic [7:0] enc_in_data;
  logic       enc_end_of_stream;
  logic       enc_rd_req;
  logic       enc_wr_req;

  modport master (
    input  recv_ready0, recv_ready1, in_data0, in_data1, eos0, eos1,
    input  enc_rd_req, enc_wr_req,
    output rd_req0, rd_req1, enc_recv_ready, enc_in_data, enc_end_of_stream
  );

  modport slave (
    output recv_ready0, recv_ready1, in_data0, in_data1, eos0, eos1,
    output enc_rd_req, enc_wr_req,
    input  rd_req0, rd_req1, enc_recv_ready, enc_in_data, enc_end_of_stream
  );
endinterface

// File: rtl/rle_stream_arb.sv
// rtl/rle_stream_arb.sv - two-FIFO whole-stream arbiter in front of one rle_enc
// Grants complete streams round-robin, flushes the encoder, then waits for its final token.
module rle_stream_arb #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  rle_stream_arb_if.master   bus,
  output logic               busy,
  output logic               grant,
  output logic               done,
  output logic [LEN_W-1:0]   stream_len,
  output logic               timed_out
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             wr_seen;
  logic [LEN_W-1:0] count;
  logic [TMR_W-1:0] timer;

  logic       any_ready;
  logic       sel_ready;
  logic       sel_eos;
  logic [7:0] sel_data;
  logic       grant_nxt;
  logic       accept;
  logic       exit_by_wr;
  logic       wait_exit;

  assign any_ready  = bus.recv_ready0 || bus.recv_ready1;
  assign sel_ready  = grant ? bus.recv_ready1 : bus.recv_ready0;
  assign sel_eos    = grant ? bus.eos1       : bus.eos0;
  assign sel_data   = grant ? bus.in_data1   : bus.in_data0;
  // Contention goes to the pointer; otherwise whichever FIFO has data.
  assign grant_nxt  = (bus.recv_ready0 && bus.recv_ready1) ? ptr : bus.recv_ready1;
  assign accept     = (state == ACTIVE) && bus.enc_rd_req && sel_ready;
  // A write seen during FLUSH is remembered so WAIT leaves after its first cycle.
  assign exit_by_wr = wr_seen || bus.enc_wr_req;
  assign wait_exit  = (state == WAIT) && (exit_by_wr || (timer == TMR_W'(TIMEOUT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_ready) state_nxt = ACTIVE;
      ACTIVE:  if (accept && sel_eos) state_nxt = FLUSH;
      FLUSH:   state_nxt = WAIT;
      WAIT:    if (wait_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_req0           = 1'b0;
    bus.rd_req1           = 1'b0;
    bus.enc_recv_ready    = 1'b0;
    bus.enc_in_data       = 8'h00;
    bus.enc_end_of_stream = 1'b0;
    busy                  = (state != IDLE);
    case (state)
      ACTIVE: begin
        bus.enc_recv_ready = sel_ready;
        bus.enc_in_data    = sel_data;
        bus.rd_req0        = !grant && bus.enc_rd_req && bus.recv_ready0;
        bus.rd_req1        =  grant && bus.enc_rd_req && bus.recv_ready1;
      end
      FLUSH:   bus.enc_end_of_stream = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 1'b0;
      ptr        <= 1'b0;
      count      <= '0;
      timer      <= '0;
      wr_seen    <= 1'b0;
      done       <= 1'b0;
      stream_len <= '0;
      timed_out  <= 1'b0;
    end else begin
      done <= wait_exit;
      if ((state == IDLE) && any_ready) begin
        grant <= grant_nxt;
      end
      if (accept && (count != '1)) begin
        count <= count + LEN_W'(1);
      end
      if (state == FLUSH) begin
        wr_seen <= bus.enc_wr_req;
        timer   <= TMR_W'(1);
      end else if (wait_exit) begin
        stream_len <= count;
        timed_out  <= !exit_by_wr;
        ptr        <= ~grant;
        count      <= '0;
        timer      <= '0;
        wr_seen    <= 1'b0;
      end else if (state == WAIT) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

endmodule
